// File: rtl/data_mem_pkg.sv
// Shared encodings and defaults for the handshaked big-endian data memory.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8002_0000;

  // Illegal size is treated as a word for range purposes; it errors anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lane_fmt.sv
// Combinational access checker and big-endian lane formatter.
// Lane i maps to byte offset+i, carried in bits [31-8i -: 8].
module data_mem_lane_fmt
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 65536,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  output logic        err,
  output logic [32:0] offset,
  output logic [3:0]  lane_we,
  output logic [31:0] lane_data,
  output logic [31:0] ld_data
);

  logic        below;
  logic        oob;
  logic        misalign;
  logic [33:0] end_off;

  assign offset = {1'b0, addr} - {1'b0, BASE_ADDR};

  always_comb begin
    below    = addr < BASE_ADDR;
    end_off  = {1'b0, offset} + 34'(size_bytes(size));
    oob      = below || (end_off > 34'(MEM_DEPTH));
    misalign = ((size == SZ_HALF) && addr[0]) ||
               ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    err      = oob || misalign || (size == SZ_ILLEGAL);
  end

  always_comb begin
    lane_we   = 4'b0000;
    lane_data = 32'h0;
    case (size)
      SZ_BYTE: begin
        lane_we   = 4'b0001;
        lane_data = {st_data[7:0], 24'h0};
      end
      SZ_HALF: begin
        lane_we   = 4'b0011;
        lane_data = {st_data[15:0], 16'h0};
      end
      SZ_WORD: begin
        lane_we   = 4'b1111;
        lane_data = st_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = 32'h0;
    case (size)
      SZ_BYTE: ld_data = is_unsigned ? {24'h0, rd_data[31:24]}
                                     : {{24{rd_data[31]}}, rd_data[31:24]};
      SZ_HALF: ld_data = is_unsigned ? {16'h0, rd_data[31:16]}
                                     : {{16{rd_data[31]}}, rd_data[31:16]};
      SZ_WORD: ld_data = rd_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressed big-endian data memory with request/response handshake
// and a configurable number of wait states between accept and response.
//   state | meaning
//   IDLE  | ready, no transaction outstanding
//   WAIT  | request latched, down-counting to the access edge
//   RESP  | one-cycle response strobe; may accept the next request
module data_mem_hs
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 65536,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        w_req_valid,
  output logic        w_req_ready,
  input  logic        w_write_op,
  input  logic [1:0]  w_size,
  input  logic        w_unsigned,
  input  logic [31:0] w_addr_32,
  input  logic [31:0] w_data_in_32,
  output logic        w_resp_valid,
  output logic [31:0] w_data_out_32,
  output logic        w_err
);

  localparam int unsigned ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;

  logic        op_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic        accept;
  logic        cnt_done;
  logic        enter_resp;
  logic        do_store;

  logic        cur_op;
  logic [1:0]  cur_size;
  logic        cur_uns;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;

  logic        fmt_err;
  logic [32:0] fmt_offset;
  logic [3:0]  fmt_we;
  logic [31:0] fmt_lane_data;
  logic [31:0] fmt_ld_data;
  logic [31:0] rd_data;
  logic [32:0] ridx;
  logic [ADDR_W-1:0] base_idx;

  logic [7:0]  mem [MEM_DEPTH];

  assign w_req_ready = (state == IDLE) || (state == RESP);
  assign accept      = w_req_valid && w_req_ready;
  assign cnt_done    = (state == WAIT) && (cnt == 4'd1);
  assign enter_resp  = (accept && (WAIT_CYCLES == 0)) || cnt_done;

  // With zero wait states the access edge is the accept edge, so the live
  // request is formatted directly instead of the not-yet-latched copy.
  assign cur_op   = accept ? w_write_op   : op_q;
  assign cur_size = accept ? w_size       : size_q;
  assign cur_uns  = accept ? w_unsigned   : uns_q;
  assign cur_addr = accept ? w_addr_32    : addr_q;
  assign cur_data = accept ? w_data_in_32 : data_q;

  assign do_store = enter_resp && cur_op && !fmt_err;
  assign base_idx = fmt_offset[ADDR_W-1:0];

  data_mem_lane_fmt #(
    .MEM_DEPTH (MEM_DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_lane_fmt (
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .addr        (cur_addr),
    .st_data     (cur_data),
    .rd_data     (rd_data),
    .err         (fmt_err),
    .offset      (fmt_offset),
    .lane_we     (fmt_we),
    .lane_data   (fmt_lane_data),
    .ld_data     (fmt_ld_data)
  );

  always_comb begin
    rd_data = 32'h0;
    ridx    = 33'h0;
    for (int i = 0; i < 4; i++) begin
      ridx = fmt_offset + 33'(i);
      if (ridx < 33'(MEM_DEPTH)) rd_data[31-8*i -: 8] = mem[ridx[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, RESP: begin
        if (accept) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
        else        next_state = IDLE;
      end
      WAIT:    if (cnt_done) next_state = RESP;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 4'd0;
      op_q   <= 1'b0;
      size_q <= SZ_BYTE;
      uns_q  <= 1'b0;
      addr_q <= 32'h0;
      data_q <= 32'h0;
    end else if (accept) begin
      cnt    <= 4'(WAIT_CYCLES);
      op_q   <= w_write_op;
      size_q <= w_size;
      uns_q  <= w_unsigned;
      addr_q <= w_addr_32;
      data_q <= w_data_in_32;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_resp_valid  <= 1'b0;
      w_data_out_32 <= 32'h0;
      w_err         <= 1'b0;
    end else if (enter_resp) begin
      w_resp_valid  <= 1'b1;
      w_data_out_32 <= (fmt_err || cur_op) ? 32'h0 : fmt_ld_data;
      w_err         <= fmt_err;
    end else if (state == RESP) begin
      w_resp_valid  <= 1'b0;
      w_data_out_32 <= 32'h0;
      w_err         <= 1'b0;
    end
  end

  // Array contents survive reset; reset only blocks a commit on its edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
    end else if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (fmt_we[i]) mem[base_idx + ADDR_W'(i)] <= fmt_lane_data[31-8*i -: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: one instance with one wait state, one with three.
module tb_data_mem_hs;
  import data_mem_pkg::*;

  logic        clock = 1'b0;
  logic        rst1, rst3, v1, v3;
  logic        op, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        rdy1, rv1, err1, rdy3, rv3, err3;
  logic [31:0] dout1, dout3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  data_mem_hs #(.WAIT_CYCLES(1)) u_dut1 (
    .clock(clock), .reset_n(rst1), .w_req_valid(v1), .w_req_ready(rdy1),
    .w_write_op(op), .w_size(size), .w_unsigned(uns), .w_addr_32(addr),
    .w_data_in_32(wdata), .w_resp_valid(rv1), .w_data_out_32(dout1), .w_err(err1)
  );

  data_mem_hs #(.WAIT_CYCLES(3)) u_dut3 (
    .clock(clock), .reset_n(rst3), .w_req_valid(v3), .w_req_ready(rdy3),
    .w_write_op(op), .w_size(size), .w_unsigned(uns), .w_addr_32(addr),
    .w_data_in_32(wdata), .w_resp_valid(rv3), .w_data_out_32(dout3), .w_err(err3)
  );

  typedef struct {
    logic        op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic o, input logic [1:0] s, input logic u,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] ed, input logic ee);
    vec_t v;
    v.op = o; v.size = s; v.uns = u; v.addr = a; v.data = d;
    v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  // lat = rising edges after the accept edge until the response is seen
  task automatic do_req(input int which, input logic o, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic re, output int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!((which == 3) ? rdy3 : rdy1) && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(n), 32'(0));
    op = o; size = s; uns = u; addr = a; wdata = d;
    if (which == 3) v3 = 1'b1; else v1 = 1'b1;
    @(posedge clock);
    #1;
    v1 = 1'b0;
    v3 = 1'b0;
    lat = 0;
    while (!((which == 3) ? rv3 : rv1) && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    rd = (which == 3) ? dout3 : dout1;
    re = (which == 3) ? err3 : err1;
    @(posedge clock);
    #1;
    chk("resp_one_cycle", 32'((which == 3) ? rv3 : rv1), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        re;
    int          lat;
    int          first, second, n, seen;

    rst1 = 1'b0; rst3 = 1'b0; v1 = 1'b0; v3 = 1'b0;
    op = 1'b0; uns = 1'b0; size = SZ_BYTE; addr = 32'h0; wdata = 32'h0;

    #2;
    chk("rst_ready", 32'(rdy1), 32'(1));
    chk("rst_resp_valid", 32'(rv1), 32'(0));
    chk("rst_data", dout1, 32'h0);
    chk("rst_err", 32'(err1), 32'(0));
    @(negedge clock);
    rst1 = 1'b1;
    rst3 = 1'b1;

    add(1, SZ_WORD,    0, 32'h8002_0000, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    add(0, SZ_WORD,    0, 32'h8002_0000, 32'h0,         32'hDEAD_BEEF, 0);
    add(0, SZ_BYTE,    0, 32'h8002_0000, 32'h0,         32'hFFFF_FFDE, 0);
    add(0, SZ_BYTE,    1, 32'h8002_0000, 32'h0,         32'h0000_00DE, 0);
    add(0, SZ_HALF,    0, 32'h8002_0002, 32'h0,         32'hFFFF_BEEF, 0);
    add(0, SZ_HALF,    1, 32'h8002_0002, 32'h0,         32'h0000_BEEF, 0);
    add(1, SZ_BYTE,    0, 32'h8002_0001, 32'h0000_0055, 32'h0000_0000, 0);
    add(0, SZ_WORD,    0, 32'h8002_0000, 32'h0,         32'hDE55_BEEF, 0);
    add(1, SZ_HALF,    0, 32'h8002_0002, 32'h0000_1234, 32'h0000_0000, 0);
    add(0, SZ_WORD,    0, 32'h8002_0000, 32'h0,         32'hDE55_1234, 0);
    add(1, SZ_WORD,    0, 32'h8002_0002, 32'hCAFE_F00D, 32'h0000_0000, 1);
    add(0, SZ_HALF,    0, 32'h8002_0001, 32'h0,         32'h0000_0000, 1);
    add(0, SZ_ILLEGAL, 0, 32'h8002_0000, 32'h0,         32'h0000_0000, 1);
    add(1, SZ_ILLEGAL, 0, 32'h8002_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    add(0, SZ_WORD,    0, 32'h8002_0000, 32'h0,         32'hDE55_1234, 0);
    add(0, SZ_WORD,    0, 32'h8001_FFFC, 32'h0,         32'h0000_0000, 1);
    add(0, SZ_BYTE,    0, 32'h8001_FFFF, 32'h0,         32'h0000_0000, 1);
    add(1, SZ_WORD,    0, 32'h8002_FFFC, 32'h0102_0304, 32'h0000_0000, 0);
    add(0, SZ_WORD,    0, 32'h8002_FFFC, 32'h0,         32'h0102_0304, 0);
    add(0, SZ_HALF,    0, 32'h8002_FFFE, 32'h0,         32'h0000_0304, 0);
    add(1, SZ_HALF,    0, 32'h8002_FFFE, 32'h0000_ABCD, 32'h0000_0000, 0);
    add(0, SZ_HALF,    0, 32'h8002_FFFE, 32'h0,         32'hFFFF_ABCD, 0);
    add(0, SZ_BYTE,    0, 32'h8002_FFFF, 32'h0,         32'hFFFF_FFCD, 0);
    add(0, SZ_WORD,    0, 32'h8002_FFFE, 32'h0,         32'h0000_0000, 1);
    add(0, SZ_WORD,    0, 32'h8003_0000, 32'h0,         32'h0000_0000, 1);
    add(0, SZ_BYTE,    0, 32'h8003_0000, 32'h0,         32'h0000_0000, 1);
    add(1, SZ_BYTE,    0, 32'h8003_0000, 32'h0000_0077, 32'h0000_0000, 1);
    add(0, SZ_WORD,    0, 32'h8002_FFFC, 32'h0,         32'h0102_ABCD, 0);

    foreach (vecs[i]) begin
      do_req(1, vecs[i].op, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].data, rd, re, lat);
      chk($sformatf("vec%0d data", i), rd, vecs[i].exp_data);
      chk($sformatf("vec%0d err", i), 32'(re), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(1));
    end

    // three wait states: baseline store, then abort a second store by reset
    do_req(3, 1, SZ_WORD, 0, 32'h8002_0010, 32'hA5A5_A5A5, rd, re, lat);
    chk("w3_store_err", 32'(re), 32'(0));
    chk("w3_latency", 32'(lat), 32'(3));

    @(negedge clock);
    op = 1'b1; size = SZ_WORD; uns = 1'b0; addr = 32'h8002_0010; wdata = 32'h1122_3344;
    v3 = 1'b1;
    @(posedge clock);
    #1;
    v3 = 1'b0;
    chk("w3_wait_not_ready", 32'(rdy3), 32'(0));
    @(negedge clock);
    rst3 = 1'b0;
    #1;
    chk("abort_resp_low", 32'(rv3), 32'(0));
    chk("abort_ready", 32'(rdy3), 32'(1));
    repeat (2) @(negedge clock);
    rst3 = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (rv3) seen = 1;
    end
    chk("abort_no_resp", 32'(seen), 32'(0));
    chk("abort_ready_after", 32'(rdy3), 32'(1));

    do_req(3, 0, SZ_WORD, 0, 32'h8002_0010, 32'h0, rd, re, lat);
    chk("abort_prior_content", rd, 32'hA5A5_A5A5);
    chk("abort_load_err", 32'(re), 32'(0));

    // back-to-back: valid held so the next request is accepted in RESP
    @(negedge clock);
    op = 1'b0; size = SZ_WORD; uns = 1'b0; addr = 32'h8002_0010; wdata = 32'h0;
    v3 = 1'b1;
    first = -1; second = -1; n = 0;
    while (second < 0 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
      if (rv3) begin
        if (first < 0) begin
          first = cyc;
          chk("b2b_first_data", dout3, 32'hA5A5_A5A5);
        end else begin
          second = cyc;
          v3 = 1'b0;
          chk("b2b_second_data", dout3, 32'hA5A5_A5A5);
        end
      end
    end
    v3 = 1'b0;
    chk("b2b_spacing", 32'(second - first), 32'(4));
    @(posedge clock);
    #1;
    chk("b2b_resp_drop", 32'(rv3), 32'(0));
    chk("b2b_idle_ready", 32'(rdy3), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
